controle_multi: RTL

- Parametrised successor to the single-pad gamepad reader.
- Scans NUM_PADS Genesis-style DB9 pads in parallel, once per video frame, triggered by the v_sync rising edge.
- Supports 3- and 6-button pads (6-button optional), auto-detects pad presence, debounces across frames and emits per-button press pulses.
- Feeds the game controller (Controlador) in place of the single-pad reader.

---
 rtl/controle_pkg.sv | 41 ++++
 rtl/controle_debounce.sv | 50 +++++
 rtl/controle_multi.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/controle_pkg.sv
// Shared constants and FSM state encoding for the multi-pad DB9 reader.
// Button bit order within a pad: {Mode,Z,Y,X,Start,C,B,A,Right,Left,Down,Up}.
package controle_pkg;

   localparam int BITS_PER_PAD = 12;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_A     = 4;
   localparam int BTN_B     = 5;
   localparam int BTN_C     = 6;
   localparam int BTN_START = 7;
   localparam int BTN_X     = 8;
   localparam int BTN_Y     = 9;
   localparam int BTN_Z     = 10;
   localparam int BTN_MODE  = 11;

   // Position of each DB9 pin inside a pad's 6-bit slice of Pinos
   localparam int PIN_P1 = 0;
   localparam int PIN_P2 = 1;
   localparam int PIN_P3 = 2;
   localparam int PIN_P4 = 3;
   localparam int PIN_P6 = 4;
   localparam int PIN_P9 = 5;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_HI1    = 4'd1,
      ST_LO1    = 4'd2,
      ST_HI2    = 4'd3,
      ST_LO2    = 4'd4,
      ST_HI3    = 4'd5,
      ST_LO3    = 4'd6,
      ST_HI4    = 4'd7,
      ST_LO4    = 4'd8,
      ST_COMMIT = 4'd9
   } state_t;

endpackage

// File: rtl/controle_debounce.sv
// Per-pad frame debouncer: a scan must repeat DEBOUNCE_FRAMES times before it
// reaches saidas; press pulses the bits that went 0->1 on that update.
module controle_debounce
   import controle_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [BITS_PER_PAD-1:0] sample,
   output logic [BITS_PER_PAD-1:0] saidas,
   output logic [BITS_PER_PAD-1:0] press
);

   localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

   logic [BITS_PER_PAD-1:0] cand_reg, saidas_reg, press_reg, saidas_next;
   logic [CW-1:0]           count_reg, count_next;

   always_comb begin
      count_next = count_reg;
      if (sample != cand_reg)
         count_next = CW'(1);
      else if (count_reg != CW'(DEBOUNCE_FRAMES))
         count_next = count_reg + CW'(1);
      saidas_next = (count_next == CW'(DEBOUNCE_FRAMES)) ? sample : saidas_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_reg   <= '0;
         count_reg  <= '0;
         saidas_reg <= '0;
         press_reg  <= '0;
      end else begin
         press_reg <= '0;
         if (en) begin
            cand_reg   <= sample;
            count_reg  <= count_next;
            saidas_reg <= saidas_next;
            press_reg  <= saidas_next & ~saidas_reg;
         end
      end
   end

   assign saidas = saidas_reg;
   assign press  = press_reg;

endmodule

// File: rtl/controle_multi.sv
// Frame-synchronous reader for NUM_PADS Genesis DB9 pads scanned in parallel.
// Define CONTROLE_SIX_BUTTON_EN to add the extra Select phases for 6-button pads.
module controle_multi
   import controle_pkg::*;
#(
   parameter int NUM_PADS        = 2,
   parameter int SETTLE_CYCLES   = 50,
   parameter int DEBOUNCE_FRAMES = 2
) (
   input  logic                               Clock50,
   input  logic                               Reset,
   input  logic                               v_sync,
   input  logic [6*NUM_PADS-1:0]              Pinos,
   output logic [NUM_PADS-1:0]                Select,
   output logic [BITS_PER_PAD*NUM_PADS-1:0]   Saidas,
   output logic [BITS_PER_PAD*NUM_PADS-1:0]   Pressionado,
   output logic [NUM_PADS-1:0]                Presente,
   output logic [NUM_PADS-1:0]                SeisBotoes,
   output logic                               Pronto
);

   localparam int CW = $clog2(SETTLE_CYCLES);

   logic                  vs_meta_reg, vs_sync_reg, vs_prev_reg, vs_rise;
   logic [6*NUM_PADS-1:0] pins_meta_reg, pins_sync_reg;
   state_t                state_reg, state_next;
   logic [CW-1:0]         phase_cnt_reg;
   logic                  phase_end, in_phase, sel, commit, pronto_reg;

   function automatic state_t next_phase(input state_t s);
      case (s)
         ST_HI1:  next_phase = ST_LO1;
`ifdef CONTROLE_SIX_BUTTON_EN
         ST_LO1:  next_phase = ST_HI2;
         ST_HI2:  next_phase = ST_LO2;
         ST_LO2:  next_phase = ST_HI3;
         ST_HI3:  next_phase = ST_LO3;
         ST_LO3:  next_phase = ST_HI4;
         ST_HI4:  next_phase = ST_LO4;
`endif
         default: next_phase = ST_COMMIT;
      endcase
   endfunction

   always_ff @(posedge Clock50 or posedge Reset) begin
      if (Reset) begin
         vs_meta_reg   <= 1'b0;
         vs_sync_reg   <= 1'b0;
         vs_prev_reg   <= 1'b0;
         pins_meta_reg <= '1;
         pins_sync_reg <= '1;
      end else begin
         vs_meta_reg   <= v_sync;
         vs_sync_reg   <= vs_meta_reg;
         vs_prev_reg   <= vs_sync_reg;
         pins_meta_reg <= Pinos;
         pins_sync_reg <= pins_meta_reg;
      end
   end

   assign vs_rise   = vs_sync_reg & ~vs_prev_reg;
   assign in_phase  = (state_reg != ST_IDLE) && (state_reg != ST_COMMIT);
   assign phase_end = in_phase && (phase_cnt_reg == CW'(SETTLE_CYCLES - 1));
   assign commit    = (state_reg == ST_COMMIT);
   assign sel       = !(state_reg inside {ST_LO1, ST_LO2, ST_LO3, ST_LO4});

   // Edges arriving mid-scan are dropped: only IDLE looks at vs_rise
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (vs_rise) state_next = ST_HI1;
         ST_COMMIT: state_next = ST_IDLE;
         default:   if (phase_end) state_next = next_phase(state_reg);
      endcase
   end

   always_ff @(posedge Clock50 or posedge Reset) begin
      if (Reset) begin
         state_reg     <= ST_IDLE;
         phase_cnt_reg <= '0;
         pronto_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         phase_cnt_reg <= (phase_end || !in_phase) ? '0 : phase_cnt_reg + CW'(1);
         pronto_reg    <= commit;
      end
   end

   assign Select = {NUM_PADS{sel}};
   assign Pronto = pronto_reg;

   for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      logic [5:0]              pins;
      logic [BITS_PER_PAD-1:0] samp_reg, sample_final;
      logic                    pres_reg, six_w, pres_out_reg, six_out_reg;

      assign pins = pins_sync_reg[6*gi +: 6];

`ifdef CONTROLE_SIX_BUTTON_EN
      logic six_reg;
      assign six_w = six_reg;
`else
      assign six_w = 1'b0;
`endif

      always_ff @(posedge Clock50 or posedge Reset) begin
         if (Reset) begin
            samp_reg <= '0;
            pres_reg <= 1'b0;
`ifdef CONTROLE_SIX_BUTTON_EN
            six_reg  <= 1'b0;
`endif
         end else if (phase_end) begin
            case (state_reg)
               ST_HI1: begin
                  samp_reg             <= '0;
                  samp_reg[BTN_UP]     <= ~pins[PIN_P1];
                  samp_reg[BTN_DOWN]   <= ~pins[PIN_P2];
                  samp_reg[BTN_LEFT]   <= ~pins[PIN_P3];
                  samp_reg[BTN_RIGHT]  <= ~pins[PIN_P4];
                  samp_reg[BTN_B]      <= ~pins[PIN_P6];
                  samp_reg[BTN_C]      <= ~pins[PIN_P9];
`ifdef CONTROLE_SIX_BUTTON_EN
                  six_reg              <= 1'b0;
`endif
               end
               ST_LO1: begin
                  samp_reg[BTN_A]      <= ~pins[PIN_P6];
                  samp_reg[BTN_START]  <= ~pins[PIN_P9];
                  pres_reg             <= ~pins[PIN_P3] & ~pins[PIN_P4];
               end
`ifdef CONTROLE_SIX_BUTTON_EN
               ST_LO3: six_reg <= ~|{pins[PIN_P4], pins[PIN_P3], pins[PIN_P2], pins[PIN_P1]};
               ST_HI4: if (six_reg) begin
                  samp_reg[BTN_Z]      <= ~pins[PIN_P1];
                  samp_reg[BTN_Y]      <= ~pins[PIN_P2];
                  samp_reg[BTN_X]      <= ~pins[PIN_P3];
                  samp_reg[BTN_MODE]   <= ~pins[PIN_P4];
               end
`endif
               default: ;
            endcase
         end
      end

      // Absent pads report nothing; extended buttons only from a 6-button pad
      assign sample_final = pres_reg ? {samp_reg[11:8] & {4{six_w}}, samp_reg[7:0]} : '0;

      always_ff @(posedge Clock50 or posedge Reset) begin
         if (Reset) begin
            pres_out_reg <= 1'b0;
            six_out_reg  <= 1'b0;
         end else if (commit) begin
            pres_out_reg <= pres_reg;
            six_out_reg  <= pres_reg & six_w;
         end
      end

      assign Presente[gi]   = pres_out_reg;
      assign SeisBotoes[gi] = six_out_reg;

      controle_debounce #(
         .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
      ) u_debounce (
         .clk    (Clock50),
         .rst    (Reset),
         .en     (commit),
         .sample (sample_final),
         .saidas (Saidas[BITS_PER_PAD*gi +: BITS_PER_PAD]),
         .press  (Pressionado[BITS_PER_PAD*gi +: BITS_PER_PAD])
      );
   end

endmodule
